// File: rtl/branch_target_buffer_pkg.sv
// -----------------------------------------------------------------------------
// branch_target_pkg
// Shared widths, the per-entry record and the PC field extractors for the
// direct-mapped branch target buffer.
//   get_index(pc) : PC[WIDTH_ENTRY_LENTH+1:2]  (word-aligned entry select)
//   get_tag(pc)   : PC[31:WIDTH_ENTRY_LENTH+2] (remaining upper PC bits)
// -----------------------------------------------------------------------------
package branch_target_pkg;

    localparam int WIDTH_DATA_LENGTH  = 32;
    localparam int WIDTH_ENTRY_LENTH  = 3;
    localparam int ENTRY_DEPTH_LENGTH = 1 << WIDTH_ENTRY_LENTH;
    localparam int WIDTH_TAG_LENGTH   = WIDTH_DATA_LENGTH - 2 - WIDTH_ENTRY_LENTH;

    typedef logic [WIDTH_DATA_LENGTH-1:0] addr_t;
    typedef logic [WIDTH_ENTRY_LENTH-1:0] idx_t;
    typedef logic [WIDTH_TAG_LENGTH-1:0]  tag_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        addr_t target;
    } btb_entry_t;

    function automatic idx_t get_index(input addr_t pc);
        return pc[WIDTH_ENTRY_LENTH+1:2];
    endfunction

    function automatic tag_t get_tag(input addr_t pc);
        return pc[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2];
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_if
// Bundles the fetch-side lookup and execute-side update signals of the BTB.
//   master : pipeline side, drives PC / PC_Ex / PC_ALU / Br_Detected /
//            Stall_Detected, receives Hit / Target_Add
//   slave  : the BTB itself
// -----------------------------------------------------------------------------
interface branch_target_buffer_if;
    import branch_target_pkg::*;

    addr_t PC;
    addr_t PC_Ex;
    addr_t PC_ALU;
    logic  Br_Detected;
    logic  Stall_Detected;
    logic  Hit;
    addr_t Target_Add;

    modport master (
        output PC, PC_Ex, PC_ALU, Br_Detected, Stall_Detected,
        input  Hit, Target_Add
    );

    modport slave (
        input  PC, PC_Ex, PC_ALU, Br_Detected, Stall_Detected,
        output Hit, Target_Add
    );
endinterface

// File: rtl/branch_target_buffer_storage.sv
// -----------------------------------------------------------------------------
// btb_storage
// Register array of ENTRY_DEPTH_LENGTH BTB entries, one write port and one
// combinational read port. Only the valid bits are reset; tag/target content
// of an invalid entry is never looked at.
//   clk, rst   : clock, synchronous active-high reset
//   i_we       : write enable
//   i_widx     : write index
//   i_wentry   : entry written
//   i_ridx     : read index
//   o_rentry   : entry at i_ridx (pre-edge contents)
// -----------------------------------------------------------------------------
module btb_storage
    import branch_target_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  idx_t       i_widx,
    input  btb_entry_t i_wentry,
    input  idx_t       i_ridx,
    output btb_entry_t o_rentry
);

    btb_entry_t r_table [ENTRY_DEPTH_LENGTH];

    // Entry array: clear valid bits on reset, otherwise write one entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_DEPTH_LENGTH; i++) begin
                r_table[i].valid <= 1'b0;
            end
        end else if (i_we) begin
            r_table[i_widx] <= i_wentry;
        end
    end

    assign o_rentry = r_table[i_ridx];

endmodule

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped 8-entry branch target buffer for the fetch stage.
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset, clears every valid bit
//   bus  : branch_target_buffer_if.slave
//          PC            fetch PC to look up (combinational, zero latency)
//          PC_Ex/PC_ALU  resolved taken branch address and its target
//          Br_Detected   taken branch resolved this cycle
//          Stall_Detected blocks any table update
//          Hit/Target_Add lookup result; Target_Add = PC+4 on a miss
// Configuration macro BTB_BYPASS_EN: when defined, an update written this
// cycle whose PC_Ex matches PC (same index and tag) is forwarded to the
// lookup in the same cycle. Undefined (default): the new entry is visible
// only after the clock edge.
// -----------------------------------------------------------------------------
module branch_target_buffer
    import branch_target_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    branch_target_buffer_if.slave bus
);

    logic       w_update_en;
    addr_t      w_pc_plus4;
    btb_entry_t w_wentry;
    btb_entry_t w_rentry;
    logic       w_hit;
    addr_t      w_target;

    assign w_update_en = bus.Br_Detected && !bus.Stall_Detected && !rst;
    assign w_pc_plus4  = bus.PC + 32'd4;

    assign w_wentry.valid  = 1'b1;
    assign w_wentry.tag    = get_tag(bus.PC_Ex);
    assign w_wentry.target = bus.PC_ALU;

    btb_storage u_storage (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_update_en),
        .i_widx   (get_index(bus.PC_Ex)),
        .i_wentry (w_wentry),
        .i_ridx   (get_index(bus.PC)),
        .o_rentry (w_rentry)
    );

    // Lookup: tag compare against the stored entry, optional same-cycle
    // forwarding of the entry being written. Reset forces a miss because the
    // valid bits are only cleared at the end of the reset cycle.
    always_comb begin
        w_hit    = 1'b0;
        w_target = w_pc_plus4;
        if (rst) begin
            w_hit    = 1'b0;
            w_target = w_pc_plus4;
        end else if (w_rentry.valid && (w_rentry.tag == get_tag(bus.PC))) begin
            w_hit    = 1'b1;
            w_target = w_rentry.target;
        end else begin
            w_hit    = 1'b0;
            w_target = w_pc_plus4;
        end
`ifdef BTB_BYPASS_EN
        if (w_update_en &&
            (get_index(bus.PC_Ex) == get_index(bus.PC)) &&
            (get_tag(bus.PC_Ex) == get_tag(bus.PC))) begin
            w_hit    = 1'b1;
            w_target = bus.PC_ALU;
        end else begin
            w_hit    = w_hit;
            w_target = w_target;
        end
`endif
    end

    assign bus.Hit        = w_hit;
    assign bus.Target_Add = w_target;

endmodule

// File: tb/tb_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer
// Directed self-checking bench for branch_target_buffer.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_failed;

`ifdef BTB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    branch_target_buffer_if bus ();

    branch_target_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Look up a PC and check Hit and Target_Add.
    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_hit, input logic [31:0] exp_tgt);
        bus.PC = pc;
        #1;
        check_value({tag, "_hit"}, {31'd0, bus.Hit}, {31'd0, exp_hit});
        check_value({tag, "_tgt"}, bus.Target_Add, exp_tgt);
    endtask

    // Advance past one rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst                = 1'b1;
        bus.PC             = 32'h0000_0100;
        bus.PC_Ex          = 32'h0000_0100;
        bus.PC_ALU         = 32'h0BAD_0BAD;
        bus.Br_Detected    = 1'b1;
        bus.Stall_Detected = 1'b0;
        tick();
        tick();
        // During reset: miss and PC+4, and the branch above must not be stored
        lookup("in_reset", 32'h0000_0100, 1'b0, 32'h0000_0104);
        bus.Br_Detected = 1'b0;
        rst = 1'b0;
        tick();
        lookup("post_reset_noupd", 32'h0000_0100, 1'b0, 32'h0000_0104);

        // 1: cold miss
        lookup("t1", 32'h1234_0000, 1'b0, 32'h1234_0004);

        // 2: insert, check pre-edge (forwarding only with bypass) and after edge
        bus.Br_Detected = 1'b1;
        bus.PC_Ex       = 32'h1234_0000;
        bus.PC_ALU      = 32'hFFFF_AAAA;
        lookup("t2_pre", 32'h1234_0000, BYPASS,
               BYPASS ? 32'hFFFF_AAAA : 32'h1234_0004);
        tick();
        bus.Br_Detected = 1'b0;
        lookup("t2_post", 32'h1234_0000, 1'b1, 32'hFFFF_AAAA);
        lookup("t2_lowbits", 32'h1234_0002, 1'b1, 32'hFFFF_AAAA);

        // 3: stalled update is dropped
        bus.Br_Detected    = 1'b1;
        bus.Stall_Detected = 1'b1;
        bus.PC_Ex          = 32'h1234_0004;
        bus.PC_ALU         = 32'h1414_1414;
        tick();
        bus.Br_Detected    = 1'b0;
        bus.Stall_Detected = 1'b0;
        lookup("t3_stall", 32'h1234_0004, 1'b0, 32'h1234_0008);
        lookup("t3_entry0", 32'h1234_0000, 1'b1, 32'hFFFF_AAAA);

        // 4: overwrite, then hold across idle edges
        bus.Br_Detected = 1'b1;
        bus.PC_Ex       = 32'h1234_0000;
        bus.PC_ALU      = 32'hAAAA_AAAA;
        tick();
        bus.Br_Detected = 1'b0;
        lookup("t4_ovr", 32'h1234_0000, 1'b1, 32'hAAAA_AAAA);
        tick();
        tick();
        lookup("t4_hold", 32'h1234_0000, 1'b1, 32'hAAAA_AAAA);

        // 5: alias on index 0 with a different tag evicts the old entry
        lookup("t5_alias_miss", 32'h1234_0020, 1'b0, 32'h1234_0024);
        bus.Br_Detected = 1'b1;
        bus.PC_Ex       = 32'h1234_0020;
        bus.PC_ALU      = 32'h5555_0000;
        tick();
        bus.Br_Detected = 1'b0;
        lookup("t5_alias_hit", 32'h1234_0020, 1'b1, 32'h5555_0000);
        lookup("t5_evicted", 32'h1234_0000, 1'b0, 32'h1234_0004);

        // PC+4 wraps to zero
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // 6: fill all indices, check, reset one edge, all miss
        for (int i = 0; i < 8; i++) begin
            bus.Br_Detected = 1'b1;
            bus.PC_Ex       = 32'h8000_0000 + 32'(i * 4);
            bus.PC_ALU      = 32'h0000_1000 + 32'(i);
            tick();
        end
        bus.Br_Detected = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lookup($sformatf("t6_fill%0d", i), 32'h8000_0000 + 32'(i * 4),
                   1'b1, 32'h0000_1000 + 32'(i));
        end
        // Reset with an update pending: both stored and pending are discarded
        rst             = 1'b1;
        bus.Br_Detected = 1'b1;
        bus.PC_Ex       = 32'h8000_0000;
        bus.PC_ALU      = 32'h0000_7777;
        lookup("t6_during_rst", 32'h8000_0004, 1'b0, 32'h8000_0008);
        tick();
        rst             = 1'b0;
        bus.Br_Detected = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lookup($sformatf("t6_cleared%0d", i), 32'h8000_0000 + 32'(i * 4),
                   1'b0, 32'h8000_0004 + 32'(i * 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
